// File: rtl/hps_mag_if.sv
// Magnitude stream into the HPS pitch estimator: one DFT bin per beat plus the
// run-time harmonic count that is sampled on the first beat of each frame.
interface hps_mag_if #(
  parameter int K_WIDTH   = 11,
  parameter int MAG_WIDTH = 32,
  parameter int H_WIDTH   = 2
) ();
  logic [MAG_WIDTH-1:0] mag_tdata;
  logic [K_WIDTH-1:0]   mag_tuser;
  logic                 mag_tvalid;
  logic                 mag_tlast;
  logic                 mag_tready;
  logic [H_WIDTH-1:0]   n_harm;

  modport master (
    output mag_tdata, mag_tuser, mag_tvalid, mag_tlast, n_harm,
    input  mag_tready
  );

  modport slave (
    input  mag_tdata, mag_tuser, mag_tvalid, mag_tlast, n_harm,
    output mag_tready
  );
endinterface

// File: rtl/hps_pitch_estimator.sv
// Harmonic-product-spectrum pitch estimator: buffers the lower half of a DFT
// magnitude frame, then scans candidate bins for the largest product of n_harm
// harmonics. Optional macro HPS_THRESHOLD_EN adds min_product / voiced gating.
module hps_pitch_estimator #(
  parameter int K_WIDTH    = 11,
  parameter int MAG_WIDTH  = 32,
  parameter int N_HARM_MAX = 3,
  parameter int H_WIDTH    = 2
) (
  input  logic                              clock,
  input  logic                              reset_n,
  hps_mag_if.slave                          mag,
`ifdef HPS_THRESHOLD_EN
  input  logic [MAG_WIDTH*N_HARM_MAX-1:0]   min_product,
  output logic                              voiced,
`endif
  output logic [K_WIDTH-1:0]                k_max,
  output logic [MAG_WIDTH*N_HARM_MAX-1:0]   max_product,
  output logic                              k_max_valid,
  output logic                              busy
);
  localparam int NB = 2 ** (K_WIDTH - 1);
  localparam int AW = K_WIDTH - 1;
  localparam int PW = MAG_WIDTH * N_HARM_MAX;

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_SCAN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [H_WIDTH-1:0]   n_lat_q, n_lat_d, n_clamp_s, scan_n_s;
  logic [K_WIDTH-1:0]   k_q, k_d, addr_q, addr_d;
  logic [H_WIDTH-1:0]   h_q, h_d;
  logic [K_WIDTH:0]     top_q, top_d, next_top_s;
  logic                 issue_q, issue_d;
  logic                 rd_vld_q, rd_first_q, rd_last_q;
  logic [K_WIDTH-1:0]   rd_k_q;
  logic [MAG_WIDTH-1:0] rd_data_q;
  logic [PW-1:0]        acc_q, acc_d, prod_s, best_q, best_d;
  logic [K_WIDTH-1:0]   best_k_q, best_k_d;
  logic                 accept_s, start_scan_s;
  logic [MAG_WIDTH-1:0] ram_q [NB];

  logic                 tready_q, busy_q, valid_q;
  logic [K_WIDTH-1:0]   k_max_q;
  logic [PW-1:0]        max_product_q;

  assign accept_s        = mag.mag_tvalid & tready_q;
  assign mag.mag_tready  = tready_q;
  assign k_max           = k_max_q;
  assign max_product     = max_product_q;
  assign k_max_valid     = valid_q;
  assign busy            = busy_q;

  // Clamp the requested harmonic count into 2..N_HARM_MAX.
  always_comb begin
    n_clamp_s = mag.n_harm;
    if (mag.n_harm < H_WIDTH'(2)) begin
      n_clamp_s = H_WIDTH'(2);
    end else if (mag.n_harm > H_WIDTH'(N_HARM_MAX)) begin
      n_clamp_s = H_WIDTH'(N_HARM_MAX);
    end else begin
      n_clamp_s = mag.n_harm;
    end
  end

  assign scan_n_s   = (state_q == S_IDLE) ? n_clamp_s : n_lat_q;
  assign next_top_s = top_q + {{(K_WIDTH + 1 - H_WIDTH){1'b0}}, n_lat_q};
  assign prod_s     = rd_first_q ? PW'(rd_data_q) : acc_q * PW'(rd_data_q);

  // Next-state, address generation and product/argmax datapath.
  always_comb begin
    state_d      = state_q;
    n_lat_d      = n_lat_q;
    k_d          = k_q;
    h_d          = h_q;
    addr_d       = addr_q;
    top_d        = top_q;
    issue_d      = issue_q;
    acc_d        = acc_q;
    best_d       = best_q;
    best_k_d     = best_k_q;
    start_scan_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          n_lat_d      = n_clamp_s;
          state_d      = mag.mag_tlast ? S_SCAN : S_STORE;
          start_scan_s = mag.mag_tlast;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STORE: begin
        if (accept_s && mag.mag_tlast) begin
          state_d      = S_SCAN;
          start_scan_s = 1'b1;
        end else begin
          state_d = S_STORE;
        end
      end
      S_SCAN: begin
        if (issue_q) begin
          // Harmonic addresses k, 2k, ... come from repeated addition; top_q tracks n*k.
          if (h_q == n_lat_q) begin
            if (next_top_s > (K_WIDTH + 1)'(NB - 1)) begin
              issue_d = 1'b0;
            end else begin
              k_d    = k_q + K_WIDTH'(1);
              addr_d = k_q + K_WIDTH'(1);
              h_d    = H_WIDTH'(1);
              top_d  = next_top_s;
            end
          end else begin
            h_d    = h_q + H_WIDTH'(1);
            addr_d = addr_q + k_q;
          end
        end else begin
          // One drain cycle (P = 1) for the registered RAM read of the final harmonic.
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_scan_s) begin
      k_d     = K_WIDTH'(1);
      addr_d  = K_WIDTH'(1);
      h_d     = H_WIDTH'(1);
      top_d   = {{(K_WIDTH + 1 - H_WIDTH){1'b0}}, scan_n_s};
      issue_d = 1'b1;
    end else begin
      issue_d = issue_d;
    end

    if (rd_vld_q) begin
      acc_d = prod_s;
      // k=1 always seeds the maximum; strictly-greater keeps the lowest k on ties.
      if (rd_last_q && ((rd_k_q == K_WIDTH'(1)) || (prod_s > best_q))) begin
        best_d   = prod_s;
        best_k_d = rd_k_q;
      end else begin
        best_d   = best_q;
        best_k_d = best_k_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // State, scan counters, read-tag pipeline and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      n_lat_q       <= H_WIDTH'(2);
      k_q           <= '0;
      h_q           <= '0;
      addr_q        <= '0;
      top_q         <= '0;
      issue_q       <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_first_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      rd_k_q        <= '0;
      acc_q         <= '0;
      best_q        <= '0;
      best_k_q      <= '0;
      tready_q      <= 1'b1;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      k_max_q       <= '0;
      max_product_q <= '0;
`ifdef HPS_THRESHOLD_EN
      voiced        <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_lat_q    <= n_lat_d;
      k_q        <= k_d;
      h_q        <= h_d;
      addr_q     <= addr_d;
      top_q      <= top_d;
      issue_q    <= issue_d;
      rd_vld_q   <= (state_q == S_SCAN) && issue_q;
      rd_first_q <= (h_q == H_WIDTH'(1));
      rd_last_q  <= (h_q == n_lat_q);
      rd_k_q     <= k_q;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_k_q   <= best_k_d;
      tready_q   <= (state_d == S_IDLE) || (state_d == S_STORE);
      busy_q     <= (state_d == S_SCAN) || (state_d == S_DONE);
      valid_q    <= (state_d == S_DONE);
      if (state_d == S_DONE) begin
        max_product_q <= best_d;
`ifdef HPS_THRESHOLD_EN
        voiced  <= (best_d >= min_product);
        k_max_q <= (best_d >= min_product) ? best_k_d : '0;
`else
        k_max_q <= best_k_d;
`endif
      end else begin
        max_product_q <= max_product_q;
        k_max_q       <= k_max_q;
      end
    end
  end

  // Frame RAM: lower-half bins written while storing, one read per scan cycle.
  always_ff @(posedge clock) begin
    if (accept_s && !mag.mag_tuser[K_WIDTH-1]) begin
      ram_q[mag.mag_tuser[AW-1:0]] <= mag.mag_tdata;
    end
    rd_data_q <= ram_q[addr_q[AW-1:0]];
  end
endmodule
